// File: rtl/rotate_commit_ctrl.sv
// rotate_commit_ctrl
//
// Turns a one-cycle rotate request into a committed piece rotation. The
// request is snapshotted, the external rotation calculator is steered with the
// captured direction/orientation, and its candidate cells are latched. Each
// candidate cell is then checked against the playfield bounds and against the
// locked-cell board memory (one registered read per cell). Up to three
// horizontal kick offsets (0, -1, +1) are tried before the rotation is
// rejected.
//
// Ports:
//   Clk, Reset                   clock, asynchronous active-high reset
//   rot_left_req, rot_right_req  one-cycle rotate requests (left wins if both)
//   block                        active piece colour (YELLOW never rotates)
//   x_block, y_block             packed cell coords, cell0=[19:15]..cell3=[4:0]
//   cur_orientation              orientation of the active piece
//   calc_rotate_left             direction to the rotation calculator
//   calc_orientation             orientation to the rotation calculator
//   calc_xblock, calc_yblock     candidate coords from the calculator
//   board_rd_en/_x/_y            board read strobe and address
//   board_rd_data                occupied flag, valid the cycle after the strobe
//   cancel                       abort an in-flight rotation silently
//   busy                         high whenever not idle
//   rot_done, rot_ok             completion pulse and accept flag
//   new_xblock, new_yblock       committed coords (held until next commit)
//   new_orientation              committed orientation
//
// Encodings: orientation NORMAL=0, ROT_LEFT=1, ROT2=2, ROT_RIGHT=3;
// block colour is 3 bits with YELLOW=2.
module rotate_commit_ctrl #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20,
  parameter int KICK_EN = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        rot_left_req,
  input  logic        rot_right_req,
  input  logic [2:0]  block,
  input  logic [19:0] x_block,
  input  logic [19:0] y_block,
  input  logic [1:0]  cur_orientation,
  output logic        calc_rotate_left,
  output logic [1:0]  calc_orientation,
  input  logic [19:0] calc_xblock,
  input  logic [19:0] calc_yblock,
  output logic        board_rd_en,
  output logic [4:0]  board_rd_x,
  output logic [4:0]  board_rd_y,
  input  logic        board_rd_data,
  input  logic        cancel,
  output logic        busy,
  output logic        rot_done,
  output logic        rot_ok,
  output logic [19:0] new_xblock,
  output logic [19:0] new_yblock,
  output logic [1:0]  new_orientation
);

  localparam logic [2:0] YELLOW = 3'd2;
  localparam logic [5:0] BW     = 6'(BOARD_W);
  localparam logic [5:0] BH     = 6'(BOARD_H);
  localparam bit         KICKS  = (KICK_EN != 0);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    READ,
    CMP,
    COMMIT,
    DONE_FAIL
  } state_t;

  state_t      state_reg;
  logic        dir_left_reg;
  logic [1:0]  orient_reg;
  logic [2:0]  block_reg;
  logic [19:0] xpos_reg;
  logic [19:0] ypos_reg;
  logic [19:0] cand_x_reg;
  logic [19:0] cand_y_reg;
  logic [1:0]  attempt_reg;
  logic [1:0]  idx_reg;
  logic        rot_done_reg;
  logic        rot_ok_reg;
  logic [19:0] new_x_reg;
  logic [19:0] new_y_reg;
  logic [1:0]  new_orient_reg;

  // Horizontal kick for the current attempt; -1 is the 5-bit wrap value.
  logic [4:0] kick;
  always_comb begin
    case (attempt_reg)
      2'd1:    kick = 5'h1F;
      2'd2:    kick = 5'h01;
      default: kick = 5'h00;
    endcase
  end

  // Unpack candidate cells and build the kicked x vector for commit.
  logic [4:0]  cand_x_cell [4];
  logic [4:0]  cand_y_cell [4];
  logic [19:0] kicked_x;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cell
      assign cand_x_cell[gi]         = cand_x_reg[19-5*gi -: 5];
      assign cand_y_cell[gi]         = cand_y_reg[19-5*gi -: 5];
      assign kicked_x[19-5*gi -: 5]  = cand_x_cell[gi] + kick;
    end
  endgenerate

  // Cell under test. A wrapped negative (e.g. 31) lands above the width
  // limit, so one unsigned compare covers both edges of the playfield.
  logic [4:0] kx;
  logic [4:0] ky;
  logic       oob;
  logic       last_attempt;
  logic [1:0] next_orient;

  assign kx           = cand_x_cell[idx_reg] + kick;
  assign ky           = cand_y_cell[idx_reg];
  assign oob          = ({1'b0, kx} >= BW) || ({1'b0, ky} >= BH);
  assign last_attempt = !KICKS || (attempt_reg == 2'd2);

  // Left steps NORMAL->ROT_LEFT->ROT2->ROT_RIGHT, right steps backwards.
  assign next_orient  = dir_left_reg ? orient_reg + 2'd1 : orient_reg - 2'd1;

  // The request snapshot of colour and position is kept for debug visibility;
  // the decisions here only need the calculator's candidates.
  logic unused_capture;
  assign unused_capture = ^{block_reg, xpos_reg, ypos_reg};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg      <= IDLE;
      dir_left_reg   <= 1'b0;
      orient_reg     <= 2'd0;
      block_reg      <= 3'd0;
      xpos_reg       <= 20'd0;
      ypos_reg       <= 20'd0;
      cand_x_reg     <= 20'd0;
      cand_y_reg     <= 20'd0;
      attempt_reg    <= 2'd0;
      idx_reg        <= 2'd0;
      rot_done_reg   <= 1'b0;
      rot_ok_reg     <= 1'b0;
      new_x_reg      <= 20'd0;
      new_y_reg      <= 20'd0;
      new_orient_reg <= 2'd0;
    end else begin
      rot_done_reg <= 1'b0;
      if (state_reg != IDLE && cancel) begin
        // Abort silently: no pulse, committed values untouched.
        state_reg <= IDLE;
      end else begin
        case (state_reg)
          IDLE: begin
            if (rot_left_req || rot_right_req) begin
              dir_left_reg <= rot_left_req;
              orient_reg   <= cur_orientation;
              block_reg    <= block;
              xpos_reg     <= x_block;
              ypos_reg     <= y_block;
              attempt_reg  <= 2'd0;
              idx_reg      <= 2'd0;
              // The O piece is rotation-invariant; reject without reads.
              state_reg    <= (block == YELLOW) ? DONE_FAIL : LATCH;
            end
          end
          LATCH: begin
            cand_x_reg  <= calc_xblock;
            cand_y_reg  <= calc_yblock;
            attempt_reg <= 2'd0;
            idx_reg     <= 2'd0;
            state_reg   <= READ;
          end
          READ: begin
            if (oob) begin
              if (last_attempt) begin
                state_reg <= DONE_FAIL;
              end else begin
                attempt_reg <= attempt_reg + 2'd1;
                idx_reg     <= 2'd0;
                state_reg   <= READ;
              end
            end else begin
              state_reg <= CMP;
            end
          end
          CMP: begin
            if (board_rd_data) begin
              if (last_attempt) begin
                state_reg <= DONE_FAIL;
              end else begin
                attempt_reg <= attempt_reg + 2'd1;
                idx_reg     <= 2'd0;
                state_reg   <= READ;
              end
            end else if (idx_reg == 2'd3) begin
              state_reg <= COMMIT;
            end else begin
              idx_reg   <= idx_reg + 2'd1;
              state_reg <= READ;
            end
          end
          COMMIT: begin
            // attempt_reg still names the winning attempt, so kicked_x is right.
            new_x_reg      <= kicked_x;
            new_y_reg      <= cand_y_reg;
            new_orient_reg <= next_orient;
            rot_done_reg   <= 1'b1;
            rot_ok_reg     <= 1'b1;
            state_reg      <= IDLE;
          end
          DONE_FAIL: begin
            rot_done_reg <= 1'b1;
            rot_ok_reg   <= 1'b0;
            state_reg    <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  // Read strobe is decoded from the state so the data returns during CMP.
  assign board_rd_en      = (state_reg == READ) && !oob;
  assign board_rd_x       = board_rd_en ? kx : 5'd0;
  assign board_rd_y       = board_rd_en ? ky : 5'd0;

  assign busy             = (state_reg != IDLE);
  assign calc_rotate_left = dir_left_reg;
  assign calc_orientation = orient_reg;
  assign rot_done         = rot_done_reg;
  assign rot_ok           = rot_ok_reg;
  assign new_xblock       = new_x_reg;
  assign new_yblock       = new_y_reg;
  assign new_orientation  = new_orient_reg;

endmodule

// File: tb/tb_rotate_commit_ctrl.sv
// Self-checking bench for rotate_commit_ctrl: directed scenarios plus
// randomized pieces/boards checked against a rule-level reference model.
module tb_rotate_commit_ctrl;

  localparam logic [2:0] CYAN      = 3'd1;
  localparam logic [2:0] YELLOW    = 3'd2;
  localparam logic [1:0] NORMAL    = 2'd0;
  localparam logic [1:0] ROT_LEFT  = 2'd1;
  localparam logic [1:0] ROT2      = 2'd2;
  localparam logic [1:0] ROT_RIGHT = 2'd3;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        rot_left_req = 1'b0;
  logic        rot_right_req = 1'b0;
  logic [2:0]  block = CYAN;
  logic [19:0] x_block = '0;
  logic [19:0] y_block = '0;
  logic [1:0]  cur_orientation = NORMAL;
  logic        calc_rotate_left;
  logic [1:0]  calc_orientation;
  logic [19:0] calc_xblock;
  logic [19:0] calc_yblock;
  logic        board_rd_en;
  logic [4:0]  board_rd_x;
  logic [4:0]  board_rd_y;
  logic        board_rd_data = 1'b0;
  logic        cancel = 1'b0;
  logic        busy;
  logic        rot_done;
  logic        rot_ok;
  logic [19:0] new_xblock;
  logic [19:0] new_yblock;
  logic [1:0]  new_orientation;

  logic [19:0] calc_x_val = '0;
  logic [19:0] calc_y_val = '0;
  assign calc_xblock = calc_x_val;
  assign calc_yblock = calc_y_val;

  rotate_commit_ctrl dut (
    .Clk(Clk), .Reset(Reset),
    .rot_left_req(rot_left_req), .rot_right_req(rot_right_req),
    .block(block), .x_block(x_block), .y_block(y_block),
    .cur_orientation(cur_orientation),
    .calc_rotate_left(calc_rotate_left), .calc_orientation(calc_orientation),
    .calc_xblock(calc_xblock), .calc_yblock(calc_yblock),
    .board_rd_en(board_rd_en), .board_rd_x(board_rd_x), .board_rd_y(board_rd_y),
    .board_rd_data(board_rd_data), .cancel(cancel),
    .busy(busy), .rot_done(rot_done), .rot_ok(rot_ok),
    .new_xblock(new_xblock), .new_yblock(new_yblock),
    .new_orientation(new_orientation)
  );

  always #5 Clk = ~Clk;

  // Locked-cell board: registered read, random garbage when not strobed.
  bit occ [32][32];
  int rd_count = 0;
  int bad_rd = 0;
  always @(posedge Clk) begin
    if (board_rd_en) begin
      board_rd_data <= occ[board_rd_x][board_rd_y];
      rd_count <= rd_count + 1;
      if (int'(board_rd_x) >= 10 || int'(board_rd_y) >= 20) bad_rd <= bad_rd + 1;
    end else begin
      board_rd_data <= 1'($urandom_range(0, 1));
    end
  end

  int vectors = 0;
  int miscompares = 0;
  logic [19:0] exp_nx = '0;
  logic [19:0] exp_ny = '0;
  logic [1:0]  exp_no = NORMAL;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_board();
    for (int x = 0; x < 32; x++)
      for (int y = 0; y < 32; y++) occ[x][y] = 1'b0;
  endtask

  function automatic logic [1:0] next_ori(input logic [1:0] o, input bit left);
    case (o)
      NORMAL:   return left ? ROT_LEFT  : ROT_RIGHT;
      ROT_LEFT: return left ? ROT2      : NORMAL;
      ROT2:     return left ? ROT_RIGHT : ROT_LEFT;
      default:  return left ? NORMAL    : ROT2;
    endcase
  endfunction

  function automatic int cell_of(input logic [19:0] v, input int c);
    logic [19:0] t;
    t = v >> (5 * (3 - c));
    return int'(t[4:0]);
  endfunction

  // Reference: walk the kick list and cells, accumulating cycle cost per rule.
  task automatic model_rot(input logic [2:0] col, input logic [19:0] cx, cy,
                           output bit ok, output int lat, output int reads,
                           output logic [19:0] nx);
    int off, kx, ky;
    bit fail;
    ok = 1'b0; lat = 1; reads = 0; nx = '0;
    if (col == YELLOW) return;
    for (int a = 0; a < 3 && !ok; a++) begin
      off = (a == 0) ? 0 : (a == 1) ? -1 : 1;
      fail = 1'b0;
      nx = '0;
      for (int c = 0; c < 4 && !fail; c++) begin
        kx = (cell_of(cx, c) + off + 32) % 32;
        ky = cell_of(cy, c);
        if (kx >= 10 || ky >= 20) begin
          lat += 1; fail = 1'b1;
        end else begin
          lat += 2; reads++;
          if (occ[kx][ky]) fail = 1'b1;
        end
        nx = nx | (20'(kx) << (5 * (3 - c)));
      end
      if (!fail) ok = 1'b1;
    end
    lat += 1;
  endtask

  // Drive one request; lat = edges after the sampling edge until rot_done.
  task automatic run_rot(input bit l, r, input logic [2:0] col, input logic [1:0] ori,
                         input logic [19:0] px, py, cx, cy, input int poke,
                         output int lat, output int reads,
                         output bit dir_seen, output logic [1:0] ori_seen);
    int base;
    @(negedge Clk);
    rot_left_req = l; rot_right_req = r; block = col; cur_orientation = ori;
    x_block = px; y_block = py; calc_x_val = cx; calc_y_val = cy;
    base = rd_count;
    @(posedge Clk);
    @(negedge Clk);
    rot_left_req = 1'b0; rot_right_req = 1'b0;
    dir_seen = calc_rotate_left; ori_seen = calc_orientation;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      if (k == poke) rot_right_req = 1'b1;
      @(posedge Clk); #1;
      if (rot_done === 1'b1) lat = k;
      @(negedge Clk);
      rot_right_req = 1'b0;
      if (lat >= 0) break;
    end
    reads = rd_count - base;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge Clk);
    #1;
    vectors++;
    if ({busy, rot_done, rot_ok, new_xblock, new_yblock, new_orientation,
         calc_rotate_left, calc_orientation, board_rd_en, board_rd_x, board_rd_y} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b done=%b ok=%b nx=%h ny=%h no=%0d want all 0",
               busy, rot_done, rot_ok, new_xblock, new_yblock, new_orientation);
    end
    @(negedge Clk);
    Reset = 1'b0;
    $display("reset released");
  endtask

  task automatic test_commit_paths();
    int lat, reads, wlat, wreads;
    bit dsn, wok;
    logic [1:0] osn, ori, wno;
    logic [19:0] px, py, cx, cy, wnx, wny;
    for (int t = 0; t < 5; t++) begin
      clear_board();
      ori = NORMAL;
      px = {5'd3, 5'd4, 5'd5, 5'd6}; py = {5'd5, 5'd5, 5'd5, 5'd5};
      cx = {5'd4, 5'd4, 5'd4, 5'd4}; cy = {5'd4, 5'd5, 5'd6, 5'd7};
      wok = 1'b1; wno = ROT_LEFT; wny = cy;
      case (t)
        0: begin wlat = 10; wreads = 4; wnx = {5'd4, 5'd4, 5'd4, 5'd4}; end
        1: begin occ[4][6] = 1'b1; wlat = 16; wreads = 7; wnx = {5'd3, 5'd3, 5'd3, 5'd3}; end
        2: begin occ[4][7] = 1'b1; wlat = 18; wreads = 8; wnx = {5'd3, 5'd3, 5'd3, 5'd3}; end
        3: begin
          for (int y = 0; y < 20; y++) begin occ[3][y] = 1'b1; occ[4][y] = 1'b1; occ[5][y] = 1'b1; end
          wlat = 8; wreads = 3; wok = 1'b0; wnx = exp_nx; wny = exp_ny; wno = exp_no;
        end
        default: begin
          ori = ROT_LEFT;
          px = {5'd0, 5'd0, 5'd0, 5'd0}; py = {5'd4, 5'd5, 5'd6, 5'd7};
          cx = {5'd31, 5'd0, 5'd1, 5'd2}; cy = {5'd6, 5'd6, 5'd6, 5'd6};
          wlat = 12; wreads = 4; wnx = {5'd0, 5'd1, 5'd2, 5'd3}; wny = cy; wno = ROT2;
        end
      endcase
      run_rot(1'b1, 1'b0, CYAN, ori, px, py, cx, cy, 0, lat, reads, dsn, osn);
      exp_nx = wnx; exp_ny = wny; exp_no = wno;
      vectors++; if (lat !== wlat) begin miscompares++; $display("FAIL path%0d latency: got %0d want %0d", t, lat, wlat); end
      vectors++; if (rot_ok !== wok) begin miscompares++; $display("FAIL path%0d rot_ok: got %b want %b", t, rot_ok, wok); end
      vectors++; if (reads !== wreads) begin miscompares++; $display("FAIL path%0d reads: got %0d want %0d", t, reads, wreads); end
      vectors++; if (new_xblock !== wnx) begin miscompares++; $display("FAIL path%0d new_x: got %h want %h", t, new_xblock, wnx); end
      vectors++; if (new_yblock !== wny) begin miscompares++; $display("FAIL path%0d new_y: got %h want %h", t, new_yblock, wny); end
      vectors++; if (new_orientation !== wno) begin miscompares++; $display("FAIL path%0d new_ori: got %0d want %0d", t, new_orientation, wno); end
      vectors++; if (dsn !== 1'b1 || osn !== ori) begin miscompares++; $display("FAIL path%0d calc_dir_ori: got %b/%0d want 1/%0d", t, dsn, osn, ori); end
      vectors++; if (bad_rd !== 0) begin miscompares++; $display("FAIL path%0d oob_reads: got %0d want 0", t, bad_rd); end
      $display("path %0d: lat=%0d ok=%b reads=%0d nx=%h ny=%h ori=%0d", t, lat, rot_ok, reads, new_xblock, new_yblock, new_orientation);
    end
  endtask

  task automatic test_yellow();
    int lat, reads;
    bit dsn;
    logic [1:0] osn;
    clear_board();
    run_rot(1'b1, 1'b0, YELLOW, NORMAL, '0, '0, {5'd4, 5'd4, 5'd4, 5'd4}, {5'd4, 5'd5, 5'd6, 5'd7},
            0, lat, reads, dsn, osn);
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL yellow latency: got %0d want 1", lat); end
    vectors++; if (rot_ok !== 1'b0) begin miscompares++; $display("FAIL yellow rot_ok: got %b want 0", rot_ok); end
    vectors++; if (reads !== 0) begin miscompares++; $display("FAIL yellow reads: got %0d want 0", reads); end
    vectors++; if ({new_xblock, new_yblock, new_orientation} !== {exp_nx, exp_ny, exp_no}) begin
      miscompares++; $display("FAIL yellow held_new: got %h/%h/%0d want %h/%h/%0d",
                              new_xblock, new_yblock, new_orientation, exp_nx, exp_ny, exp_no);
    end
    $display("yellow: lat=%0d ok=%b reads=%0d", lat, rot_ok, reads);
  endtask

  task automatic test_both_requests();
    int lat, reads;
    bit dsn;
    logic [1:0] osn, wno;
    clear_board();
    for (int t = 0; t < 2; t++) begin
      run_rot(1'b1, t == 0, CYAN, NORMAL, {5'd3, 5'd4, 5'd5, 5'd6}, {5'd5, 5'd5, 5'd5, 5'd5},
              {5'd4, 5'd4, 5'd4, 5'd4}, {5'd4, 5'd5, 5'd6, 5'd7}, 0, lat, reads, dsn, osn);
      wno = next_ori(NORMAL, 1'b1);
      vectors++; if (new_orientation !== wno) begin miscompares++; $display("FAIL both%0d new_ori: got %0d want %0d", t, new_orientation, wno); end
      vectors++; if (dsn !== 1'b1) begin miscompares++; $display("FAIL both%0d calc_dir: got %b want 1", t, dsn); end
      vectors++; if (lat !== 10 || rot_ok !== 1'b1) begin miscompares++; $display("FAIL both%0d done: got lat=%0d ok=%b want 10/1", t, lat, rot_ok); end
      $display("left request (right=%0d): ori=%0d lat=%0d", t == 0, new_orientation, lat);
    end
    run_rot(1'b0, 1'b1, CYAN, NORMAL, '0, '0, {5'd4, 5'd4, 5'd4, 5'd4}, {5'd4, 5'd5, 5'd6, 5'd7},
            0, lat, reads, dsn, osn);
    exp_nx = {5'd4, 5'd4, 5'd4, 5'd4}; exp_ny = {5'd4, 5'd5, 5'd6, 5'd7}; exp_no = ROT_RIGHT;
    vectors++; if (new_orientation !== ROT_RIGHT) begin miscompares++; $display("FAIL right new_ori: got %0d want %0d", new_orientation, ROT_RIGHT); end
    vectors++; if (dsn !== 1'b0) begin miscompares++; $display("FAIL right calc_dir: got %b want 0", dsn); end
    $display("right request: ori=%0d lat=%0d", new_orientation, lat);
  endtask

  task automatic test_cancel();
    int pulses = 0;
    clear_board();
    @(negedge Clk);
    rot_left_req = 1'b1; block = CYAN; cur_orientation = NORMAL;
    calc_x_val = {5'd1, 5'd1, 5'd1, 5'd1}; calc_y_val = {5'd0, 5'd1, 5'd2, 5'd3};
    @(posedge Clk);
    @(negedge Clk); rot_left_req = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL cancel pre_busy: got %b want 1", busy); end
    @(negedge Clk); cancel = 1'b1;
    @(posedge Clk); #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL cancel busy: got %b want 0", busy); end
    vectors++; if (board_rd_en !== 1'b0) begin miscompares++; $display("FAIL cancel rd_en: got %b want 0", board_rd_en); end
    @(negedge Clk); cancel = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge Clk); #1;
      if (rot_done === 1'b1) pulses++;
    end
    vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL cancel pulses: got %0d want 0", pulses); end
    vectors++; if ({new_xblock, new_yblock, new_orientation} !== {exp_nx, exp_ny, exp_no}) begin
      miscompares++; $display("FAIL cancel held_new: got %h/%h/%0d want %h/%h/%0d",
                              new_xblock, new_yblock, new_orientation, exp_nx, exp_ny, exp_no);
    end
    $display("cancel: busy=%b pulses=%0d", busy, pulses);
  endtask

  task automatic test_async_reset();
    int lat, reads;
    bit dsn;
    logic [1:0] osn;
    clear_board();
    @(negedge Clk);
    rot_left_req = 1'b1; block = CYAN; cur_orientation = NORMAL;
    calc_x_val = {5'd4, 5'd4, 5'd4, 5'd4}; calc_y_val = {5'd4, 5'd5, 5'd6, 5'd7};
    @(posedge Clk);
    @(negedge Clk); rot_left_req = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL areset pre_busy: got %b want 1", busy); end
    #2 Reset = 1'b1;
    #1;
    vectors++;
    if ({busy, rot_done, rot_ok, new_xblock, new_yblock, new_orientation,
         calc_rotate_left, calc_orientation, board_rd_en, board_rd_x, board_rd_y} !== '0) begin
      miscompares++;
      $display("FAIL areset_outputs: got busy=%b ok=%b nx=%h ny=%h no=%0d dir=%b want all 0",
               busy, rot_ok, new_xblock, new_yblock, new_orientation, calc_rotate_left);
    end
    @(negedge Clk); Reset = 1'b0;
    exp_nx = '0; exp_ny = '0; exp_no = NORMAL;
    run_rot(1'b1, 1'b0, CYAN, NORMAL, {5'd3, 5'd4, 5'd5, 5'd6}, {5'd5, 5'd5, 5'd5, 5'd5},
            {5'd4, 5'd4, 5'd4, 5'd4}, {5'd4, 5'd5, 5'd6, 5'd7}, 0, lat, reads, dsn, osn);
    exp_nx = {5'd4, 5'd4, 5'd4, 5'd4}; exp_ny = {5'd4, 5'd5, 5'd6, 5'd7}; exp_no = ROT_LEFT;
    vectors++; if (lat !== 10 || rot_ok !== 1'b1) begin miscompares++; $display("FAIL areset next: got lat=%0d ok=%b want 10/1", lat, rot_ok); end
    vectors++; if (new_xblock !== exp_nx || new_orientation !== exp_no) begin
      miscompares++; $display("FAIL areset next_new: got %h/%0d want %h/%0d", new_xblock, new_orientation, exp_nx, exp_no);
    end
    $display("after async reset: lat=%0d ok=%b", lat, rot_ok);
  endtask

  task automatic test_random();
    logic [19:0] cx, cy, m_nx;
    logic [2:0] col;
    logic [1:0] ori, osn;
    bit l, r, m_ok, dsn;
    int base, m_lat, m_reads, lat, reads, poke, bad0, mode;
    for (int n = 0; n < 40; n++) begin
      for (int x = 0; x < 10; x++)
        for (int y = 0; y < 20; y++) occ[x][y] = ($urandom_range(0, 4) == 0);
      base = $urandom_range(0, 11);
      cx = '0; cy = '0;
      for (int c = 0; c < 4; c++) begin
        cx = (cx << 5) | 20'((base + $urandom_range(0, 3) + 31) % 32);
        cy = (cy << 5) | 20'($urandom_range(0, 20));
      end
      col = 3'($urandom_range(1, 7));
      ori = 2'($urandom_range(0, 3));
      mode = $urandom_range(0, 2);
      l = (mode != 1); r = (mode != 0);
      model_rot(col, cx, cy, m_ok, m_lat, m_reads, m_nx);
      poke = ($urandom_range(0, 1) == 1) ? $urandom_range(1, m_lat) : 0;
      bad0 = bad_rd;
      run_rot(l, r, col, ori, 20'($urandom), 20'($urandom), cx, cy, poke, lat, reads, dsn, osn);
      if (m_ok) begin exp_nx = m_nx; exp_ny = cy; exp_no = next_ori(ori, l); end
      vectors++; if (lat !== m_lat) begin miscompares++; $display("FAIL rnd%0d latency: got %0d want %0d", n, lat, m_lat); end
      vectors++; if (rot_ok !== m_ok) begin miscompares++; $display("FAIL rnd%0d rot_ok: got %b want %b", n, rot_ok, m_ok); end
      vectors++; if (reads !== m_reads) begin miscompares++; $display("FAIL rnd%0d reads: got %0d want %0d", n, reads, m_reads); end
      vectors++; if (new_xblock !== exp_nx || new_yblock !== exp_ny) begin
        miscompares++; $display("FAIL rnd%0d new_xy: got %h/%h want %h/%h", n, new_xblock, new_yblock, exp_nx, exp_ny);
      end
      vectors++; if (new_orientation !== exp_no) begin miscompares++; $display("FAIL rnd%0d new_ori: got %0d want %0d", n, new_orientation, exp_no); end
      vectors++; if (bad_rd !== bad0) begin miscompares++; $display("FAIL rnd%0d oob_reads: got %0d want %0d", n, bad_rd, bad0); end
      vectors++; if (dsn !== l || osn !== ori) begin miscompares++; $display("FAIL rnd%0d calc_dir_ori: got %b/%0d want %b/%0d", n, dsn, osn, l, ori); end
      @(posedge Clk); #1;
      vectors++; if (busy !== 1'b0 || rot_done !== 1'b0) begin
        miscompares++; $display("FAIL rnd%0d idle_after: got busy=%b done=%b want 0/0", n, busy, rot_done);
      end
      $display("rnd %0d: col=%0d ori=%0d l=%b r=%b poke=%0d lat=%0d ok=%b reads=%0d nx=%h",
               n, col, ori, l, r, poke, lat, rot_ok, reads, new_xblock);
    end
  endtask

  initial begin
    clear_board();
    test_reset();
    test_commit_paths();
    test_yellow();
    test_both_requests();
    test_cancel();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
